// File: rtl/tone_frame_ctrl.sv
// Frame controller behind the six-tone detector: locks a detector group on sync, captures command bits and hands frames to the host.
// Optional even-parity checking on par_err is built when TONE_FRAME_PARITY_EN is defined.
module tone_frame_ctrl #(
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned SYNC_MIN   = 64,
  parameter int unsigned TIMEOUT    = 4000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic [2:0]            det_g0,
  input  logic [2:0]            det_g1,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_grp,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  par_err
);
  localparam int unsigned SC_W = $clog2(SYNC_MIN + 1);
  localparam int unsigned BC_W = $clog2(FRAME_BITS + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_HOLD} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_grp, w_grp_nxt;
  logic                  r_last_grp, w_last_grp_nxt;
  logic                  r_c_q, w_c_q_nxt;
  logic [SC_W-1:0]       r_sync_cnt, w_sync_cnt_nxt;
  logic [BC_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [TO_W-1:0]       r_to_cnt, w_to_cnt_nxt;
  logic [FRAME_BITS-2:0] r_shreg, w_shreg_nxt;
  logic [FRAME_BITS-1:0] w_frame_data_nxt;
  logic                  w_frame_grp_nxt;
  logic                  w_frame_valid_nxt;
  logic                  w_err_nxt;

  logic [2:0]            w_det;
  logic                  w_s, w_c, w_m, w_edge;
  logic [FRAME_BITS-1:0] w_shift;

  // Bits of the currently locked group
  assign w_det   = r_grp ? det_g1 : det_g0;
  assign w_s     = w_det[2];
  assign w_c     = w_det[1];
  assign w_m     = w_det[0];
  assign w_edge  = w_c & ~r_c_q;
  assign w_shift = {r_shreg, w_m};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_grp       <= 1'b0;
      r_last_grp  <= 1'b1;
      r_c_q       <= 1'b0;
      r_sync_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_to_cnt    <= '0;
      r_shreg     <= '0;
      frame_data  <= '0;
      frame_grp   <= 1'b0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_grp       <= w_grp_nxt;
      r_last_grp  <= w_last_grp_nxt;
      r_c_q       <= w_c_q_nxt;
      r_sync_cnt  <= w_sync_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_shreg     <= w_shreg_nxt;
      frame_data  <= w_frame_data_nxt;
      frame_grp   <= w_frame_grp_nxt;
      frame_valid <= w_frame_valid_nxt;
      busy        <= (w_state_nxt != S_IDLE);
      err_timeout <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_grp_nxt         = r_grp;
    w_last_grp_nxt    = r_last_grp;
    w_c_q_nxt         = r_c_q;
    w_sync_cnt_nxt    = r_sync_cnt;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_to_cnt_nxt      = r_to_cnt;
    w_shreg_nxt       = r_shreg;
    w_frame_data_nxt  = frame_data;
    w_frame_grp_nxt   = frame_grp;
    w_frame_valid_nxt = frame_valid;
    w_err_nxt         = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Tie goes to the group that did not deliver the previous frame
        if (clk_enable && (det_g0[2] || det_g1[2])) begin
          w_grp_nxt      = (det_g0[2] && det_g1[2]) ? ~r_last_grp : det_g1[2];
          w_sync_cnt_nxt = '0;
          w_state_nxt    = S_SYNC;
        end
      end
      S_SYNC: begin
        if (clk_enable) begin
          if (w_s) begin
            if (r_sync_cnt < SC_W'(SYNC_MIN)) w_sync_cnt_nxt = r_sync_cnt + SC_W'(1);
          end else if (r_sync_cnt == SC_W'(SYNC_MIN)) begin
            w_shreg_nxt   = '0;
            w_bit_cnt_nxt = '0;
            w_to_cnt_nxt  = '0;
            w_state_nxt   = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (clk_enable) begin
          if (w_s) begin
            w_sync_cnt_nxt = '0;
            w_state_nxt    = S_SYNC;
          end else if (w_edge) begin
            w_shreg_nxt   = w_shift[FRAME_BITS-2:0];
            w_bit_cnt_nxt = r_bit_cnt + BC_W'(1);
            w_to_cnt_nxt  = '0;
            if (w_bit_cnt_nxt == BC_W'(FRAME_BITS)) begin
              w_frame_data_nxt  = w_shift;
              w_frame_grp_nxt   = r_grp;
              w_frame_valid_nxt = 1'b1;
              w_state_nxt       = S_HOLD;
            end
          end else begin
            if (r_to_cnt < TO_W'(TIMEOUT)) w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            if (w_to_cnt_nxt == TO_W'(TIMEOUT)) begin
              w_err_nxt   = 1'b1;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_HOLD: begin
        // Handshake is sampled every clock, independent of clk_enable
        if (frame_valid && frame_ready) begin
          w_frame_valid_nxt = 1'b0;
          w_last_grp_nxt    = frame_grp;
          w_state_nxt       = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Loading from the next group makes a clock tone already present at lock not count as an edge
    if (clk_enable) w_c_q_nxt = w_grp_nxt ? det_g1[1] : det_g0[1];
  end

`ifdef TONE_FRAME_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_err <= 1'b0;
    end else if (w_frame_valid_nxt && !frame_valid) begin
      par_err <= ^w_shift;
    end else if (!w_frame_valid_nxt) begin
      par_err <= 1'b0;
    end
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tone_frame_ctrl.sv
// Self-checking bench for tone_frame_ctrl: directed frames with a frame/timeout scoreboard checked every cycle.
module tb_tone_frame_ctrl;
  localparam int unsigned FB = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clk_enable = 1'b0;
  logic          frame_ready = 1'b0;
  logic [2:0]    det_g0 = 3'b000;
  logic [2:0]    det_g1 = 3'b000;
  logic [FB-1:0] frame_data;
  logic          frame_grp, frame_valid, busy, err_timeout, par_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit slow    = 1'b0;
  int locked  = 0;
  int exp_to  = 0;

  typedef struct {
    logic [FB-1:0] data;
    logic          grp;
  } frame_t;
  frame_t exp_q[$];

  tone_frame_ctrl dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .det_g0(det_g0), .det_g1(det_g1),
    .frame_data(frame_data), .frame_grp(frame_grp), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .busy(busy), .err_timeout(err_timeout), .par_err(par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One enabled sample; in slow mode it is preceded by a disabled cycle
  task automatic en_cycle();
    if (slow) begin
      clk_enable = 1'b0;
      @(negedge clk);
    end
    clk_enable = 1'b1;
    @(negedge clk);
  endtask

  // Locked group gets {s,c,m}; the other group carries clock/command noise, never sync
  task automatic drive(input logic s, input logic c, input logic m);
    logic [2:0] nz;
    nz = {1'b0, 2'($urandom)};
    if (locked == 0) begin
      det_g0 = {s, c, m};
      det_g1 = nz;
    end else begin
      det_g1 = {s, c, m};
      det_g0 = nz;
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      en_cycle();
    end
  endtask

  task automatic release_sync();
    drive(1'b0, 1'b0, 1'b0);
    en_cycle();
  endtask

  task automatic send_bits(input logic [FB-1:0] v, input int k);
    for (int i = 0; i < k; i++) begin
      drive(1'b0, 1'b1, v[FB-1-i]);
      en_cycle();
      drive(1'b0, 1'b0, v[FB-1-i]);
      en_cycle();
    end
  endtask

  // Caller has already locked the group; runs sync hold, release and all FB bits
  task automatic run_frame(input int g, input logic [FB-1:0] v);
    frame_t f;
    f.data = v;
    f.grp  = 1'(g);
    exp_q.push_back(f);
    hold(64);
    chk("busy_in_sync", 32'(busy), 32'd1);
    release_sync();
    send_bits(v, FB - 1);
    chk("valid_before_last_edge", 32'(frame_valid), 32'd0);
    chk("busy_in_data", 32'(busy), 32'd1);
    drive(1'b0, 1'b1, v[0]);
    en_cycle();
    chk("valid_latency", 32'(frame_valid), 32'd1);
  endtask

  // Scoreboard compare: frames, stability while held, timeout pulses
  logic          prev_valid = 1'b0;
  logic          prev_err = 1'b0;
  logic [FB-1:0] held_data;
  logic          held_grp;
  always @(negedge clk) begin : mon
    frame_t e;
    logic   exp_par;
    if (!reset) begin
      prev_valid = 1'b0;
      prev_err   = 1'b0;
    end else begin
      if (frame_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: got data 0x%0h grp %0d, expected no frame", frame_data, frame_grp);
        end else begin
          e = exp_q.pop_front();
`ifdef TONE_FRAME_PARITY_EN
          exp_par = ^e.data;
`else
          exp_par = 1'b0;
`endif
          chk("frame_data", 32'(frame_data), 32'(e.data));
          chk("frame_grp", 32'(frame_grp), 32'(e.grp));
          chk("par_err", 32'(par_err), 32'(exp_par));
        end
        held_data = frame_data;
        held_grp  = frame_grp;
      end else if (frame_valid) begin
        chk("data_stable", 32'(frame_data), 32'(held_data));
        chk("grp_stable", 32'(frame_grp), 32'(held_grp));
      end
      if (frame_valid) chk("busy_with_valid", 32'(busy), 32'd1);
      if (err_timeout) begin
        chk("timeout_expected", 32'(exp_to > 0), 32'd1);
        chk("timeout_one_cycle", 32'(prev_err), 32'd0);
        chk("idle_after_timeout", 32'(busy), 32'd0);
        if (exp_to > 0) exp_to--;
      end
      prev_valid = frame_valid;
      prev_err   = err_timeout;
    end
  end

  initial begin
    // Reset values
    @(negedge clk);
    chk("rst_frame_data", 32'(frame_data), 32'd0);
    chk("rst_frame_grp", 32'(frame_grp), 32'd0);
    chk("rst_frame_valid", 32'(frame_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_par", 32'(par_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Group 0 frame 0xA5C3, then held with ready low while sync toggles
    locked = 0;
    drive(1'b1, 1'b0, 1'b0);
    en_cycle();
    chk("busy_after_lock", 32'(busy), 32'd1);
    run_frame(0, 16'hA5C3);
    chk("a5c3_literal", 32'(frame_data), 32'h0000_A5C3);
    chk("a5c3_grp", 32'(frame_grp), 32'd0);
    for (int i = 0; i < 100; i++) begin
      det_g0 = {1'(i % 3 == 0), 2'($urandom)};
      det_g1 = {1'(i % 4 < 2), 2'($urandom)};
      clk_enable = 1'(i % 2);
      @(negedge clk);
    end
    det_g0 = 3'b000;
    det_g1 = 3'b000;
    clk_enable = 1'b1;
    chk("hold_valid", 32'(frame_valid), 32'd1);
    chk("hold_data", 32'(frame_data), 32'h0000_A5C3);
    chk("hold_busy", 32'(busy), 32'd1);
    frame_ready = 1'b1;
    @(negedge clk);
    chk("xfer_valid_low", 32'(frame_valid), 32'd0);
    chk("xfer_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("no_relock", 32'(busy), 32'd0);

    // Group 1 sync one cycle short
    locked = 1;
    drive(1'b1, 1'b0, 1'b0);
    en_cycle();
    hold(63);
    chk("short_sync_busy", 32'(busy), 32'd1);
    release_sync();
    chk("short_sync_idle", 32'(busy), 32'd0);
    chk("short_sync_no_err", 32'(err_timeout), 32'd0);
    repeat (3) en_cycle();

    // Timeout after 5 bits on group 1
    drive(1'b1, 1'b0, 1'b0);
    en_cycle();
    hold(64);
    release_sync();
    chk("to_data_busy", 32'(busy), 32'd1);
    send_bits(16'hD800, 5);
    for (int i = 0; i < 3998; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      en_cycle();
    end
    chk("to_not_yet", 32'(err_timeout), 32'd0);
    chk("to_still_busy", 32'(busy), 32'd1);
    exp_to = 1;
    en_cycle();
    chk("to_pulse", 32'(err_timeout), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    en_cycle();
    chk("to_pulse_end", 32'(err_timeout), 32'd0);

    // Resync mid-DATA on group 1 with a slow strobe, then a full frame
    slow = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    en_cycle();
    hold(64);
    release_sync();
    send_bits(16'hFFFF, 3);
    drive(1'b1, 1'b0, 1'b0);
    en_cycle();
    chk("resync_busy", 32'(busy), 32'd1);
    chk("resync_no_err", 32'(err_timeout), 32'd0);
    run_frame(1, 16'h0F0F);
    chk("resync_grp", 32'(frame_grp), 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("resync_xfer", 32'(frame_valid), 32'd0);
    slow = 1'b0;

    // Asynchronous reset mid-DATA on group 0
    locked = 0;
    drive(1'b1, 1'b0, 1'b0);
    en_cycle();
    hold(64);
    release_sync();
    send_bits(16'h5A5A, 7);
    reset = 1'b0;
    #1;
    chk("arst_frame_data", 32'(frame_data), 32'd0);
    chk("arst_frame_grp", 32'(frame_grp), 32'd0);
    chk("arst_valid", 32'(frame_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err_timeout), 32'd0);
    chk("arst_par", 32'(par_err), 32'd0);
    det_g0 = 3'b000;
    det_g1 = 3'b000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Two ties in succession: group 0 first, then group 1
    det_g0 = 3'b100;
    det_g1 = 3'b100;
    en_cycle();
    chk("tie1_busy", 32'(busy), 32'd1);
    locked = 0;
    run_frame(0, 16'hA5C2);
    chk("tie1_grp", 32'(frame_grp), 32'd0);
    det_g0 = 3'b100;
    det_g1 = 3'b100;
    @(negedge clk);
    chk("tie1_xfer_valid", 32'(frame_valid), 32'd0);
    chk("tie1_xfer_idle", 32'(busy), 32'd0);
    en_cycle();
    chk("tie2_lock_next", 32'(busy), 32'd1);
    locked = 1;
    run_frame(1, 16'h8001);
    chk("tie2_grp", 32'(frame_grp), 32'd1);
    det_g0 = 3'b000;
    det_g1 = 3'b000;
    @(negedge clk);
    chk("tie2_xfer", 32'(frame_valid), 32'd0);
    repeat (4) @(negedge clk);

    chk("all_frames_seen", 32'(exp_q.size()), 32'd0);
    chk("all_timeouts_seen", 32'(exp_to), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tone_frame_ctrl.md
# tone_frame_ctrl

Frame controller behind the six-tone detector. It arbitrates between the two detector groups (group 0: 3475/5110/7395 Hz, group 1: 4240/6205/8900 Hz) and locks onto whichever group presents a valid sync tone. It then sequences bit capture: on each clock-tone rising edge it samples the command tone and shifts it into a frame. The assembled frame is handed to the host over a valid/ready handshake.

## Interface

Parameters:
- FRAME_BITS, 16: bits per frame (2..32).
- SYNC_MIN, 64: enabled cycles sync tone must be held before a frame may start (≥1).
- TIMEOUT, 4000: enabled cycles allowed between clock-tone edges in DATA (≥2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- clk_enable  in  1  sample strobe; the same strobe that drives the detectors.
- det_g0  in  3  group 0 detector bits {sync, clk, cmd} = {det_out_2, det_out_1, det_out_0}.
- det_g1  in  3  group 1 detector bits {sync, clk, cmd} = {det_out1_2, det_out1_1, det_out1_0}.
- frame_data  out  FRAME_BITS  captured frame; first received bit is MSB.
- frame_grp  out  1  group that produced frame_data.
- frame_valid  out  1  frame available.
- frame_ready  in  1  host accepts frame.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  one-cycle pulse when DATA times out.
- par_err  out  1  parity error flag qualified by frame_valid (see Configuration).

## Operation

- States: IDLE, SYNC, DATA, HOLD. Every transition except the HOLD exit is taken only in cycles with clk_enable=1.
- Locked-group bits: s, c, m. c_q is the registered c, updated on enabled cycles. A clock edge is c & ~c_q in an enabled cycle.
- IDLE:
  - If exactly one group's sync bit is high, lock that group.
  - If both are high, lock the group that is NOT last_grp (round-robin). last_grp resets to 1, so group 0 wins the first tie.
  - On lock: clear sync_cnt, go to SYNC.
- SYNC:
  - While s=1, sync_cnt increments and saturates at SYNC_MIN.
  - If s falls with sync_cnt<SYNC_MIN, return to IDLE silently.
  - If s falls with sync_cnt=SYNC_MIN, clear the shift register, bit_cnt and to_cnt, then go to DATA.
  - On SYNC entry, c_q is loaded from the current c, so a clock tone already present does not count as an edge.
- DATA:
  - On each clock edge: shreg <= {shreg[FRAME_BITS-2:0], m}, bit_cnt++, to_cnt clears.
  - On any other enabled cycle, to_cnt++.
  - When bit_cnt reaches FRAME_BITS, load frame_data/frame_grp, set frame_valid, go to HOLD.
  - If to_cnt reaches TIMEOUT: pulse err_timeout, go to IDLE, discard the partial frame.
  - If s rises (resync): clear sync_cnt and go to SYNC, discarding the partial frame, no error. A timeout in the same cycle as a resync loses to the resync.
- HOLD:
  - frame_valid stays high and frame_data stays stable until frame_valid & frame_ready, sampled every clk regardless of clk_enable.
  - On transfer: drop frame_valid, set last_grp=frame_grp, go to IDLE.
  - Detector activity during HOLD is ignored, including sync on either group.
- Counters are saturating and sized to clog2(parameter+1).

## Timing

- Reset values: frame_data=0, frame_grp=0, frame_valid=0, busy=0, err_timeout=0, par_err=0, state=IDLE, last_grp=1.
- A reset assertion mid-frame returns to IDLE immediately and asynchronously. The partial frame is lost.
- Frame latency: frame_valid rises on the clk edge following the enabled cycle that detects the FRAME_BITS-th clock edge.
- Transfer timing: with frame_ready already high, the transfer completes one cycle after frame_valid rises. The next sync can be accepted one cycle after that.
- err_timeout is high for exactly one clk cycle.
- busy is registered from the state and changes on the same edge as the state register.

## Configuration

- TONE_FRAME_PARITY_EN defined:
  - frame_data[0] is an even-parity bit over frame_data[FRAME_BITS-1:1].
  - par_err is registered together with frame_valid and is high if the XOR of all FRAME_BITS bits is 1.
  - The frame is still delivered.
- TONE_FRAME_PARITY_EN undefined: par_err is tied to 0 and no parity logic is built.

## Test plan

- Group 0 sync held for 64 enabled cycles then released, followed by 16 clock edges carrying 0xA5C3 → frame_valid with frame_data=0xA5C3, frame_grp=0, busy high throughout.
- Sync on group 1 held for only 63 cycles, then released → return to IDLE, no frame, no err_timeout.
- Both groups' sync rise in the same cycle, twice in succession (frames completed and accepted) → the first frame comes from group 0, the second from group 1.
- Clock edges stop after 5 bits → exactly 4000 enabled cycles later err_timeout pulses for 1 cycle and the state returns to IDLE.
- Frame completes with frame_ready held low for 100 cycles while new sync toggles → frame_data stable, no new lock; ready high → transfer; reset asserted mid-DATA on a later frame → all outputs return to reset values.
- With TONE_FRAME_PARITY_EN, frame 0xA5C2 (odd total parity) → par_err=1; 0xA5C3 → par_err=0.
